// File: rtl/spi_sram_master.sv
// SPI mode-0 initiator turning single-word read/write requests into 23LC1024 serial SRAM
// frames: command byte, 24-bit byte address, 16 data bits, MSB first on a single data line.
module spi_sram_master #(
   parameter int unsigned HALF_PERIOD = 2,
   parameter int unsigned ADDR_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  resetb,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [15:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [15:0]           rsp_rdata,
   output logic                  spi_cs_n,
   output logic                  spi_sck,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic                  spi_hold_n
);

   localparam int unsigned HcntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [HcntW-1:0] HcntLast = HcntW'(HALF_PERIOD - 1);
   localparam logic [HcntW-1:0] HcntOne  = HcntW'(1);
   localparam logic [7:0] CmdWrite = 8'h02;
   localparam logic [7:0] CmdRead  = 8'h03;
   localparam logic [5:0] BitFirst = 6'd47;

   typedef enum logic [1:0] {StIdle, StStart, StShift, StEnd} state_t;

   state_t            state_q, state_d;
   logic [HcntW-1:0]  hcnt_q, hcnt_d;
   logic [5:0]        bit_q, bit_d;
   logic              tail_q, tail_d;
   logic [47:0]       shift_q, shift_d;
   logic [15:0]       rx_q, rx_d;
   logic              we_q, we_d;
   logic              cs_n_q, cs_n_d;
   logic              sck_q, sck_d;
   logic              mosi_q, mosi_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [15:0]       rsp_rdata_q, rsp_rdata_d;
   logic [23:0]       byte_addr;
   logic [47:0]       frame;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q     <= StIdle;
         hcnt_q      <= '0;
         bit_q       <= '0;
         tail_q      <= 1'b0;
         shift_q     <= '0;
         rx_q        <= '0;
         we_q        <= 1'b0;
         cs_n_q      <= 1'b1;
         sck_q       <= 1'b0;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         bit_q       <= bit_d;
         tail_q      <= tail_d;
         shift_q     <= shift_d;
         rx_q        <= rx_d;
         we_q        <= we_d;
         cs_n_q      <= cs_n_d;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      bit_d       = bit_q;
      tail_d      = tail_q;
      shift_d     = shift_q;
      rx_d        = rx_q;
      we_d        = we_q;
      cs_n_d      = cs_n_q;
      sck_d       = sck_q;
      mosi_d      = mosi_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;

      byte_addr = '0;
      byte_addr[ADDR_WIDTH:0] = {req_addr, 1'b0};
      frame = {(req_we ? CmdWrite : CmdRead), byte_addr, (req_we ? req_wdata : 16'h0000)};

      unique case (state_q)
         StIdle: begin
         end
         StStart: begin
            if (hcnt_q == '0) begin
               state_d = StShift;
               hcnt_d  = HcntLast;
               sck_d   = 1'b1;
               rx_d    = {rx_q[14:0], spi_miso};
            end else begin
               hcnt_d = hcnt_q - HcntOne;
            end
         end
         StShift: begin
            if (hcnt_q != '0) begin
               hcnt_d = hcnt_q - HcntOne;
            end else begin
               hcnt_d = HcntLast;
               if (sck_q) begin
                  sck_d = 1'b0;
                  if (bit_q == '0) begin
                     tail_d = 1'b1;
                     mosi_d = 1'b0;
                  end else begin
                     bit_d   = bit_q - 6'd1;
                     shift_d = {shift_q[46:0], 1'b0};
                     mosi_d  = shift_q[46];
                  end
               end else if (tail_q) begin
                  // One extra low half-period of hold before deselecting.
                  state_d     = StEnd;
                  cs_n_d      = 1'b1;
                  rsp_valid_d = 1'b1;
                  ready_d     = (HALF_PERIOD == 1);
                  if (!we_q) begin
                     rsp_rdata_d = rx_q;
                  end
               end else begin
                  sck_d = 1'b1;
                  rx_d  = {rx_q[14:0], spi_miso};
               end
            end
         end
         StEnd: begin
            // Ready rises one cycle early so a held request starts exactly H cycles after cs_n rises.
            if (hcnt_q == '0) begin
               state_d = StIdle;
            end else begin
               hcnt_d = hcnt_q - HcntOne;
               if (hcnt_q == HcntOne) begin
                  ready_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (req_valid && ready_q) begin
         state_d = StStart;
         hcnt_d  = HcntLast;
         bit_d   = BitFirst;
         tail_d  = 1'b0;
         shift_d = frame;
         mosi_d  = frame[47];
         cs_n_d  = 1'b0;
         sck_d   = 1'b0;
         ready_d = 1'b0;
         we_d    = req_we;
      end
   end

   assign req_ready  = ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign spi_cs_n   = cs_n_q;
   assign spi_sck    = sck_q;
   assign spi_mosi   = mosi_q;
   assign spi_hold_n = 1'b1;

endmodule

// File: tb/tb_spi_sram_master.sv
// Bench for spi_sram_master: an H=2 and an H=1 instance, each with a behavioural serial SRAM,
// checked against a word-level reference memory.
module tb_spi_sram_master;

   logic clock  = 1'b0;
   logic resetb = 1'b1;
   always #5 clock = ~clock;

   logic [1:0]       req_valid = '0;
   logic [1:0]       req_we    = '0;
   logic [1:0][15:0] req_addr  = '0;
   logic [1:0][15:0] req_wdata = '0;
   wire  [1:0]       req_ready, rsp_valid, cs_n, sck, mosi, hold_n;
   wire  [1:0][15:0] rsp_rdata;

   int checks = 0;
   int errors = 0;
   logic [15:0] ref_mem [int];

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      logic        cs_n_w, sck_w, mosi_w, hold_w, ready_w, valid_w;
      logic [15:0] rdata_w;
      logic        miso = 1'b0;
      logic [7:0]  mem [int];
      int          rises = 0, sck_total = 0, frames = 0, pulses = 0;
      logic [47:0] cap = '0;
      logic [7:0]  rd_cmd = '0;
      logic [23:0] rd_addr = '0;

      spi_sram_master #(.HALF_PERIOD(g == 0 ? 2 : 1), .ADDR_WIDTH(16)) dut (
         .clock      (clock),
         .resetb     (resetb),
         .req_valid  (req_valid[g]),
         .req_ready  (ready_w),
         .req_we     (req_we[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .rsp_valid  (valid_w),
         .rsp_rdata  (rdata_w),
         .spi_cs_n   (cs_n_w),
         .spi_sck    (sck_w),
         .spi_mosi   (mosi_w),
         .spi_miso   (miso),
         .spi_hold_n (hold_w)
      );

      assign req_ready[g] = ready_w;
      assign rsp_valid[g] = valid_w;
      assign rsp_rdata[g] = rdata_w;
      assign cs_n[g]      = cs_n_w;
      assign sck[g]       = sck_w;
      assign mosi[g]      = mosi_w;
      assign hold_n[g]    = hold_w;

      always @(posedge sck_w) begin
         sck_total++;
         if (!cs_n_w) begin
            cap = {cap[46:0], mosi_w};
            rises++;
            if (rises == 32) begin
               rd_cmd  = cap[31:24];
               rd_addr = cap[23:0];
            end
         end
      end

      always @(negedge cs_n_w) begin
         rises = 0;
         cap   = '0;
      end

      // Sequential-mode SRAM: data bits leave on SCK falling edges after the address.
      always @(negedge sck_w) begin
         if (!cs_n_w && rises >= 32 && rises < 48 && rd_cmd == 8'h03) begin
            int k;
            logic [7:0] b;
            k = int'(rd_addr) + (rises - 32) / 8;
            b = mem.exists(k) ? mem[k] : 8'h00;
            miso = b[7 - ((rises - 32) % 8)];
         end
      end

      always @(posedge cs_n_w) begin
         frames++;
         if (rises == 48 && cap[47:40] == 8'h02) begin
            mem[int'(cap[39:16])]     = cap[15:8];
            mem[int'(cap[39:16]) + 1] = cap[7:0];
         end
      end

      always @(negedge clock) begin
         if (valid_w) pulses++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_rd(input int g, input logic [15:0] a);
      int key;
      key = g * 65536 + int'(a);
      return ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
   endfunction

   task automatic wait_ready(input int g);
      int n;
      n = 0;
      @(negedge clock);
      while (req_ready[g] !== 1'b1 && n < 1000) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic xact(input int g, input logic we, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd);
      wait_ready(g);
      req_we[g]    = we;
      req_addr[g]  = a;
      req_wdata[g] = d;
      req_valid[g] = 1'b1;
      @(posedge clock);
      #1 req_valid[g] = 1'b0;
      lat = -1;
      rd  = 'x;
      for (int k = 1; k <= 1000; k++) begin
         @(posedge clock);
         #1;
         if (rsp_valid[g] === 1'b1) begin
            lat = k;
            rd  = rsp_rdata[g];
            break;
         end
      end
   endtask

   task automatic run(input int g, input logic we, input logic [15:0] a, input logic [15:0] d,
                      input string tag);
      int          lat;
      int          h;
      logic [15:0] rd, exp_rd;
      logic [47:0] exp_frame;
      h = (g == 0) ? 2 : 1;
      exp_rd = model_rd(g, a);
      exp_frame = {(we ? 8'h02 : 8'h03), 24'(32'(a) * 2), (we ? d : 16'h0000)};
      xact(g, we, a, d, lat, rd);
      chk({tag, "_lat"}, 64'(lat), 64'(97 * h));
      if (g == 0) begin
         chk({tag, "_frame"}, 64'(gen_dut[0].cap), 64'(exp_frame));
         chk({tag, "_rises"}, 64'(gen_dut[0].rises), 64'd48);
      end
      if (!we) chk({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
      else ref_mem[g * 65536 + int'(a)] = d;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] a, d;
      int          n, p0, f0;
      logic        seen;

      #1 resetb = 1'b0;
      repeat (5) @(negedge clock);
      chk("rst_cs_n", 64'(cs_n), 64'h3);
      chk("rst_sck", 64'(sck), 64'h0);
      chk("rst_mosi", 64'(mosi), 64'h0);
      chk("rst_hold_n", 64'(hold_n), 64'h3);
      chk("rst_ready", 64'(req_ready), 64'h3);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rdata", 64'(rsp_rdata), 64'h0);
      resetb = 1'b1;
      repeat (20) @(negedge clock);
      chk("idle_sck_edges", 64'(gen_dut[0].sck_total + gen_dut[1].sck_total), 64'h0);
      chk("idle_cs_n", 64'(cs_n), 64'h3);

      run(0, 1'b1, 16'h1234, 16'hBEEF, "wr_1234");
      run(0, 1'b0, 16'h1234, 16'h0000, "rd_1234");
      run(0, 1'b1, 16'h0042, 16'h1357, "wr_0042");
      chk("rdata_held", 64'(rsp_rdata[0]), 64'hBEEF);
      run(0, 1'b1, 16'hFFFF, 16'hA5C3, "wr_ffff");
      chk("baddr_ffff", 64'(gen_dut[0].cap[39:16]), 64'h01FFFE);
      run(0, 1'b0, 16'hFFFF, 16'h0000, "rd_ffff");
      run(0, 1'b0, 16'h0000, 16'h0000, "rd_0000");

      for (int i = 0; i < 10; i++) begin
         a = 16'(16'h4000 + $urandom_range(0, 5));
         d = 16'($urandom);
         run(0, 1'($urandom_range(0, 1)), a, d, "rand");
      end

      // Back-to-back: valid held across two writes.
      wait_ready(0);
      p0 = gen_dut[0].pulses;
      f0 = gen_dut[0].frames;
      req_we[0] = 1'b1; req_addr[0] = 16'h0100; req_wdata[0] = 16'h0F0F; req_valid[0] = 1'b1;
      @(posedge clock);
      #1 req_addr[0] = 16'h0101; req_wdata[0] = 16'hF0F0;
      n = 0;
      seen = 1'b0;
      while (n < 1000) begin
         @(posedge clock);
         n++;
         #1;
         if (cs_n[0]) seen = 1'b1;
         else if (seen) break;
      end
      req_valid[0] = 1'b0;
      chk("b2b_gap", 64'(n), 64'd196);
      ref_mem[16'h0100] = 16'h0F0F;
      ref_mem[16'h0101] = 16'hF0F0;
      n = 0;
      while (rsp_valid[0] !== 1'b1 && n < 1000) begin
         @(posedge clock);
         n++;
         #1;
      end
      chk("b2b_frame2", 64'(gen_dut[0].cap), 64'h02_000202_F0F0);
      repeat (3) @(negedge clock);
      chk("b2b_pulses", 64'(gen_dut[0].pulses - p0), 64'd2);
      chk("b2b_frames", 64'(gen_dut[0].frames - f0), 64'd2);
      run(0, 1'b0, 16'h0100, 16'h0000, "rd_0100");

      // Pulse while busy is ignored.
      wait_ready(0);
      p0 = gen_dut[0].pulses;
      f0 = gen_dut[0].frames;
      req_we[0] = 1'b0; req_addr[0] = 16'h0101; req_valid[0] = 1'b1;
      @(posedge clock);
      #1 req_valid[0] = 1'b0;
      repeat (50) @(negedge clock);
      req_we[0] = 1'b1; req_addr[0] = 16'h0200; req_wdata[0] = 16'hDEAD; req_valid[0] = 1'b1;
      @(negedge clock);
      req_valid[0] = 1'b0;
      n = 0;
      while (rsp_valid[0] !== 1'b1 && n < 1000) begin
         @(posedge clock);
         n++;
         #1;
      end
      chk("busy_rdata", 64'(rsp_rdata[0]), 64'(model_rd(0, 16'h0101)));
      repeat (300) @(negedge clock);
      chk("busy_pulses", 64'(gen_dut[0].pulses - p0), 64'd1);
      chk("busy_frames", 64'(gen_dut[0].frames - f0), 64'd1);
      run(0, 1'b0, 16'h0200, 16'h0000, "rd_0200");

      // Reset mid-frame after SCK edge 20.
      wait_ready(0);
      p0 = gen_dut[0].pulses;
      req_we[0] = 1'b0; req_addr[0] = 16'h1234; req_valid[0] = 1'b1;
      @(posedge clock);
      #1 req_valid[0] = 1'b0;
      n = 0;
      while (gen_dut[0].rises < 20 && n < 1000) begin
         @(negedge clock);
         n++;
      end
      chk("mid_rises", 64'(gen_dut[0].rises), 64'd20);
      #2 resetb = 1'b0;
      #1;
      chk("mid_cs_n", 64'(cs_n[0]), 64'h1);
      chk("mid_sck", 64'(sck[0]), 64'h0);
      chk("mid_mosi", 64'(mosi[0]), 64'h0);
      repeat (3) @(negedge clock);
      resetb = 1'b1;
      repeat (5) @(negedge clock);
      chk("mid_no_pulse", 64'(gen_dut[0].pulses - p0), 64'd0);
      chk("mid_rdata_rst", 64'(rsp_rdata[0]), 64'h0);
      run(0, 1'b0, 16'h1234, 16'h0000, "rd_after_rst");

      // HALF_PERIOD=1 instance.
      a = 16'($urandom);
      d = 16'($urandom);
      run(1, 1'b1, a, d, "h1_wr");
      run(1, 1'b0, a, 16'h0000, "h1_rd");
      run(1, 1'b0, 16'(a ^ 16'h0001), 16'h0000, "h1_rd_other");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
